// File: rtl/cnt_burst_arbiter_if.sv
// Bundle of requester-side and counter-side signals shared by the burst arbiter.
// The master side is the requesters plus the counter; the slave side is the arbiter.
interface cnt_burst_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 5
);

  logic [N_REQ-1:0]       req;
  logic [2*N_REQ-1:0]     op;
  logic [WIDTH*N_REQ-1:0] arg;
  logic [N_REQ-1:0]       gnt;
  logic                   done;
  logic                   sat;
  logic                   busy;
  logic                   cnt_load;
  logic                   cnt_up;
  logic                   cnt_down;
  logic [WIDTH-1:0]       cnt_in;
  logic                   cnt_high;
  logic                   cnt_low;

  modport master (
    output req, op, arg, cnt_high, cnt_low,
    input  gnt, done, sat, busy, cnt_load, cnt_up, cnt_down, cnt_in
  );

  modport slave (
    input  req, op, arg, cnt_high, cnt_low,
    output gnt, done, sat, busy, cnt_load, cnt_up, cnt_down, cnt_in
  );

endinterface

// File: rtl/cnt_burst_arbiter.sv
// Round-robin arbiter that lends one saturating up/down counter to N_REQ
// requesters, issuing one load/up/down strobe per cycle for the granted
// requester and finishing with a done pulse that carries saturation status.
module cnt_burst_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 5
) (
  input logic              clk,
  input logic              rst,
  cnt_burst_arbiter_if.slave bus
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_UP   = 2'b01;
  localparam logic [1:0] OP_DOWN = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic               done_q, done_d;
  logic               sat_q, sat_d;
  logic               busy_q, busy_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [1:0]         op_r_q, op_r_d;
  logic [WIDTH-1:0]   arg_r_q, arg_r_d;
  logic [WIDTH-1:0]   rem_q, rem_d;

  logic               found;
  int                 scan_idx;
  int                 sel_idx;
  logic [1:0]         sel_op;
  logic [WIDTH-1:0]   sel_arg;
  logic               run_act;

  // Next-state logic: round-robin pick in IDLE, one step per cycle in RUN,
  // single done cycle before returning to IDLE.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    sat_d    = sat_q;
    ptr_d    = ptr_q;
    op_r_d   = op_r_q;
    arg_r_d  = arg_r_q;
    rem_d    = rem_q;
    found    = 1'b0;
    scan_idx = 0;
    sel_idx  = 0;
    sel_op   = OP_NOP;
    sel_arg  = '0;

    case (state_q)
      IDLE: begin
        gnt_d = '0;
        sat_d = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
          scan_idx = (int'(ptr_q) + i) % N_REQ;
          if (!found && bus.req[scan_idx]) begin
            found   = 1'b1;
            sel_idx = scan_idx;
          end
        end
        if (found) begin
          sel_op         = bus.op[2*sel_idx +: 2];
          sel_arg        = bus.arg[WIDTH*sel_idx +: WIDTH];
          gnt_d[sel_idx] = 1'b1;
          op_r_d         = sel_op;
          arg_r_d        = sel_arg;
          rem_d          = sel_arg;
          ptr_d          = PTR_W'((sel_idx + 1) % N_REQ);
          if (sel_op == OP_NOP || (sel_op != OP_LOAD && sel_arg == '0)) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end

      RUN: begin
        case (op_r_q)
          OP_LOAD: begin
            state_d = DONE;
            sat_d   = 1'b0;
          end
          OP_UP: begin
            if (!bus.cnt_high) begin
              rem_d = rem_q - WIDTH'(1);
              if (rem_q == WIDTH'(1)) begin
                state_d = DONE;
                sat_d   = 1'b0;
              end
            end else begin
              state_d = DONE;
              sat_d   = 1'b1;
            end
          end
          OP_DOWN: begin
            if (!bus.cnt_low) begin
              rem_d = rem_q - WIDTH'(1);
              if (rem_q == WIDTH'(1)) begin
                state_d = DONE;
                sat_d   = 1'b0;
              end
            end else begin
              state_d = DONE;
              sat_d   = 1'b1;
            end
          end
          default: begin
            state_d = DONE;
            sat_d   = 1'b0;
          end
        endcase
      end

      DONE: begin
        state_d = IDLE;
        gnt_d   = '0;
        sat_d   = 1'b0;
      end

      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        sat_d   = 1'b0;
      end
    endcase

    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset aborts any burst and rewinds the pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      done_q  <= 1'b0;
      sat_q   <= 1'b0;
      busy_q  <= 1'b0;
      ptr_q   <= '0;
      op_r_q  <= OP_NOP;
      arg_r_q <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      sat_q   <= sat_d;
      busy_q  <= busy_d;
      ptr_q   <= ptr_d;
      op_r_q  <= op_r_d;
      arg_r_q <= arg_r_d;
      rem_q   <= rem_d;
    end
  end

  // Counter strobes follow the current state directly; reset suppresses them
  // so an aborted burst does not sneak in one more step.
  assign run_act = (state_q == RUN) && !rst;

  assign bus.cnt_load = run_act && (op_r_q == OP_LOAD);
  assign bus.cnt_up   = run_act && (op_r_q == OP_UP)   && !bus.cnt_high;
  assign bus.cnt_down = run_act && (op_r_q == OP_DOWN) && !bus.cnt_low;
  assign bus.cnt_in   = bus.cnt_load ? arg_r_q : '0;

  assign bus.gnt  = gnt_q;
  assign bus.done = done_q;
  assign bus.sat  = sat_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_cnt_burst_arbiter.sv
// Directed bench for cnt_burst_arbiter: a table of single transactions plus
// hand-written round-robin, mid-burst change and mid-burst reset sequences.
module tb_cnt_burst_arbiter;

  localparam int N_REQ = 4;
  localparam int WIDTH = 5;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_UP   = 2'b01;
  localparam logic [1:0] OP_DOWN = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  logic clk;
  logic rst;

  cnt_burst_arbiter_if #(.N_REQ(N_REQ), .WIDTH(WIDTH)) bus ();

  cnt_burst_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference saturating counter fed by the arbiter's strobes; the preset
  // port lets the bench place the counter at a chosen start value.
  logic [WIDTH-1:0] cnt_model;
  logic             preset_en;
  logic [WIDTH-1:0] preset_val;

  always_ff @(posedge clk) begin
    if (preset_en) begin
      cnt_model <= preset_val;
    end else if (bus.cnt_load) begin
      cnt_model <= bus.cnt_in;
    end else if (bus.cnt_up && cnt_model != '1) begin
      cnt_model <= cnt_model + WIDTH'(1);
    end else if (bus.cnt_down && cnt_model != '0) begin
      cnt_model <= cnt_model - WIDTH'(1);
    end
  end

  assign bus.cnt_high = (cnt_model == '1);
  assign bus.cnt_low  = (cnt_model == '0);

  int compared;
  int mismatched;

  // One comparison: counts it and reports a FAIL line when it disagrees.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [2*N_REQ-1:0] opf(input int slot, input logic [1:0] code);
    logic [2*N_REQ-1:0] v;
    v = '0;
    v[2*slot +: 2] = code;
    return v;
  endfunction

  function automatic logic [WIDTH*N_REQ-1:0] argf(input int slot, input logic [WIDTH-1:0] val);
    logic [WIDTH*N_REQ-1:0] v;
    v = '0;
    v[WIDTH*slot +: WIDTH] = val;
    return v;
  endfunction

  // Places the reference counter at a known value while the arbiter idles.
  task automatic presetCounter(input logic [WIDTH-1:0] v);
    preset_val = v;
    preset_en  = 1'b1;
    @(posedge clk);
    #1;
    preset_en  = 1'b0;
  endtask

  // Drives one request set, follows the burst until done and reports grant,
  // cycles-to-done, strobe count and sat; req becomes next_req on done.
  task automatic applyStimulus(input logic [N_REQ-1:0] req_in,
                               input logic [2*N_REQ-1:0] op_in,
                               input logic [WIDTH*N_REQ-1:0] arg_in,
                               input logic [N_REQ-1:0] next_req,
                               input bit mid_change,
                               output logic [N_REQ-1:0] got_gnt,
                               output int lat,
                               output int strobes,
                               output logic got_sat);
    int cyc;
    bit seen_done;
    bus.req = req_in;
    bus.op  = op_in;
    bus.arg = arg_in;
    strobes   = 0;
    got_sat   = 1'b0;
    seen_done = 1'b0;
    lat       = -1;
    @(posedge clk);
    #1;
    got_gnt = bus.gnt;
    checkOutput("busy_after_grant", 32'(bus.busy), 32'd1);
    cyc = 1;
    while (!seen_done && cyc <= 40) begin
      checkOutput("strobe_onehot",
                  32'(int'(bus.cnt_load) + int'(bus.cnt_up) + int'(bus.cnt_down) <= 1), 32'd1);
      strobes += int'(bus.cnt_load) + int'(bus.cnt_up) + int'(bus.cnt_down);
      if (bus.done) begin
        seen_done = 1'b1;
        lat       = cyc;
        got_sat   = bus.sat;
        bus.req   = next_req;
      end else begin
        if (mid_change && cyc == 1) begin
          bus.op  = {N_REQ{OP_DOWN}};
          bus.arg = '0;
        end
        @(posedge clk);
        #1;
        cyc++;
      end
    end
    if (!seen_done) begin
      checkOutput("done_timeout", 32'd1, 32'd0);
      bus.req = '0;
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [WIDTH-1:0]       start;
    logic [N_REQ-1:0]       req;
    logic [2*N_REQ-1:0]     op;
    logic [WIDTH*N_REQ-1:0] arg;
    logic [N_REQ-1:0]       exp_gnt;
    int                     exp_lat;
    int                     exp_strb;
    logic                   exp_sat;
    logic [WIDTH-1:0]       exp_cnt;
  } vec_t;

  vec_t vecs[10];

  logic [N_REQ-1:0] g;
  int               l;
  int               s;
  logic             st;

  // Main sequence: reset values, table, then the multi-cycle corner cases.
  initial begin
    compared   = 0;
    mismatched = 0;
    rst        = 1'b1;
    preset_en  = 1'b0;
    preset_val = '0;
    bus.req    = '0;
    bus.op     = '0;
    bus.arg    = '0;

    // Transactions run back to back; the expected grant follows the pointer.
    vecs[0] = '{5'd0,  4'b0001, opf(0, OP_LOAD), argf(0, 5'd10), 4'b0001, 2, 1, 1'b0, 5'd10};
    vecs[1] = '{5'd10, 4'b0001, opf(0, OP_UP),   argf(0, 5'd3),  4'b0001, 4, 3, 1'b0, 5'd13};
    vecs[2] = '{5'd30, 4'b0001, opf(0, OP_UP),   argf(0, 5'd3),  4'b0001, 3, 1, 1'b1, 5'd31};
    vecs[3] = '{5'd1,  4'b0001, opf(0, OP_DOWN), argf(0, 5'd4),  4'b0001, 3, 1, 1'b1, 5'd0};
    vecs[4] = '{5'd5,  4'b0010, opf(1, OP_NOP),  argf(1, 5'd7),  4'b0010, 1, 0, 1'b0, 5'd5};
    vecs[5] = '{5'd5,  4'b0100, opf(2, OP_UP),   argf(2, 5'd0),  4'b0100, 1, 0, 1'b0, 5'd5};
    vecs[6] = '{5'd20, 4'b1000, opf(3, OP_DOWN), argf(3, 5'd2),  4'b1000, 3, 2, 1'b0, 5'd18};
    vecs[7] = '{5'd31, 4'b0001, opf(0, OP_UP),   argf(0, 5'd2),  4'b0001, 2, 0, 1'b1, 5'd31};
    vecs[8] = '{5'd0,  4'b0110, opf(1, OP_LOAD) | opf(2, OP_UP),
                argf(1, 5'd31) | argf(2, 5'd5),  4'b0010, 2, 1, 1'b0, 5'd31};
    vecs[9] = '{5'd3,  4'b1001, opf(0, OP_DOWN) | opf(3, OP_UP),
                argf(0, 5'd2) | argf(3, 5'd1),   4'b1000, 2, 1, 1'b0, 5'd4};

    @(posedge clk);
    #1;
    checkOutput("reset_gnt",  32'(bus.gnt),      32'd0);
    checkOutput("reset_done", 32'(bus.done),     32'd0);
    checkOutput("reset_sat",  32'(bus.sat),      32'd0);
    checkOutput("reset_busy", 32'(bus.busy),     32'd0);
    checkOutput("reset_strb", 32'({bus.cnt_load, bus.cnt_up, bus.cnt_down}), 32'd0);
    checkOutput("reset_cin",  32'(bus.cnt_in),   32'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      presetCounter(vecs[i].start);
      applyStimulus(vecs[i].req, vecs[i].op, vecs[i].arg, '0, 1'b0, g, l, s, st);
      checkOutput($sformatf("v%0d_gnt", i),  32'(g),         32'(vecs[i].exp_gnt));
      checkOutput($sformatf("v%0d_lat", i),  32'(l),         32'(vecs[i].exp_lat));
      checkOutput($sformatf("v%0d_strb", i), 32'(s),         32'(vecs[i].exp_strb));
      checkOutput($sformatf("v%0d_sat", i),  32'(st),        32'(vecs[i].exp_sat));
      checkOutput($sformatf("v%0d_cnt", i),  32'(cnt_model), 32'(vecs[i].exp_cnt));
    end

    // Round robin from a fresh pointer: all four requesters hold req while
    // requester 0 re-asserts right after its first service; it must wait its turn.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    presetCounter(5'd0);
    begin
      logic [N_REQ-1:0] rr_req  [5];
      logic [N_REQ-1:0] rr_next [5];
      logic [N_REQ-1:0] rr_exp  [5];
      rr_req  = '{4'b1111, 4'b1111, 4'b1101, 4'b1001, 4'b0001};
      rr_next = '{4'b1111, 4'b1101, 4'b1001, 4'b0001, 4'b0000};
      rr_exp  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      for (int i = 0; i < 5; i++) begin
        applyStimulus(rr_req[i], {N_REQ{OP_UP}}, {N_REQ{5'd1}}, rr_next[i], 1'b0, g, l, s, st);
        checkOutput($sformatf("rr%0d_gnt", i), 32'(g), 32'(rr_exp[i]));
        checkOutput($sformatf("rr%0d_lat", i), 32'(l), 32'd2);
      end
      checkOutput("rr_cnt", 32'(cnt_model), 32'd5);
    end

    // Opcode and argument are captured at grant; rewriting them mid-burst
    // must not alter the running UP-by-3.
    presetCounter(5'd10);
    applyStimulus(4'b0001, opf(0, OP_UP), argf(0, 5'd3), '0, 1'b1, g, l, s, st);
    checkOutput("mid_gnt",  32'(g),         32'd1);
    checkOutput("mid_lat",  32'(l),         32'd4);
    checkOutput("mid_strb", 32'(s),         32'd3);
    checkOutput("mid_cnt",  32'(cnt_model), 32'd13);

    // Reset during an UP-by-8 burst on requester 2, after three strobes.
    presetCounter(5'd0);
    bus.req = 4'b0100;
    bus.op  = opf(2, OP_UP);
    bus.arg = argf(2, 5'd8);
    @(posedge clk);
    #1;
    bus.req = '0;
    checkOutput("rb_gnt", 32'(bus.gnt), 32'b0100);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("rb_up%0d", i), 32'(bus.cnt_up), 32'd1);
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    checkOutput("rb_no_strobe", 32'(bus.cnt_up), 32'd0);
    checkOutput("rb_no_done",   32'(bus.done),   32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("rb_idle_gnt%0d", i),  32'(bus.gnt),  32'd0);
      checkOutput($sformatf("rb_idle_done%0d", i), 32'(bus.done), 32'd0);
      checkOutput($sformatf("rb_idle_busy%0d", i), 32'(bus.busy), 32'd0);
      @(posedge clk);
      #1;
    end
    checkOutput("rb_cnt", 32'(cnt_model), 32'd3);
    applyStimulus(4'b1010, '0, '0, '0, 1'b0, g, l, s, st);
    checkOutput("rb_ptr_gnt", 32'(g), 32'b0010);
    checkOutput("rb_ptr_lat", 32'(l), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
